fir: RTL and testbench
======================

Name: fir

Overview:
- Parameterised direct-form FIR filter on a signed Q1.15 sample stream with a valid-qualified input.
- One output sample per accepted input sample, after a fixed pipeline latency.
- Default configuration is an 8-tap moving average (all coefficients 0.125).
- Sits in the datapath between a sample source and downstream DSP/monitor logic.

Parameters:
- NUM_TAPS, 8, number of taps (2..32).
- COEFFS, {NUM_TAPS{16'sh1000}}, packed array of NUM_TAPS signed Q1.15 coefficients; entry 0 multiplies the newest sample.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  data_in is valid this cycle; sample is accepted at the rising edge.
- data_in  input  16  signed Q1.15 input sample.
- valid_out  output  1  data_out is valid this cycle; single-cycle pulse per output sample.
- data_out  output  16  signed Q1.15 filtered sample, held between pulses.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset is asynchronous and active-low, rst_n.
- Reset:
  - Delay line cleared to 0; all pipeline valids cleared.
  - valid_out=0, data_out=0.
  - Asserting reset mid-stream drops all in-flight samples; no valid_out until new input is accepted.
- Delay line:
  - On a clk edge with valid_in=1: x[0]<=data_in and x[i]<=x[i-1].
  - With valid_in=0 the delay line holds; idle gaps do not insert zeros.
- Arithmetic:
  - y = sum over i of COEFFS[i]*x[i].
  - Each product is full 32-bit signed.
  - Accumulator is 32+clog2(NUM_TAPS) bits; no intermediate truncation.
- Output conversion:
  - Shift the accumulator right arithmetically by 15, with rounding per FIR_ROUND_EN.
  - Saturate to [-32768, 32767].
  - Saturation is always on.
- Pipeline (3 register stages):
  - Edge T: delay-line update.
  - Edge T+1: products and adder tree registered.
  - Edge T+2: round/saturate into data_out.
  - A sample accepted at edge T gives valid_out=1 for exactly the cycle after edge T+2 (latency 3 edges, observable at edge T+3).
- Throughput:
  - valid_in may be high every cycle; the outputs form back-to-back pulses.
- No backpressure: the downstream consumer must always accept.
- data_out changes only on an output pulse and keeps its last value otherwise.
- Number of valid_out pulses equals number of accepted samples.
- Ordering is preserved.

Optional Feature:
- Macro: FIR_ROUND_EN.
- Defined: round half-up, i.e. add 2^14 to the accumulator before the >>>15.
- Undefined: truncate toward negative infinity (plain >>>15); one fewer adder.
- Latency is identical in both builds.

Test Plan:
- Reset check: hold rst_n=0 for 5 cycles -> valid_out=0 and data_out=0x0000; no pulses until the first valid_in.
- Step response (FIR_ROUND_EN defined): release reset, send 8 x 0x7FFF with idle cycles between samples -> outputs 0x1000, 0x2000, 0x3000, 0x4000, 0x5000, 0x6000, 0x7000, 0x7FFF. Each output lands 3 edges after its input.
- Square wave: 4 x 0x7FFF then 4 x 0x8000 from a cleared state -> 8th output = 0x0000; outputs 5..7 = 0x3000, 0x2000, 0x1000.
- Truncation build (FIR_ROUND_EN undefined): single 0x7FFF from reset -> 0x0FFF; after 4 x 0x7FFF -> 0x3FFF.
- Repeated pattern: 3 x (4 x 0x7FFF, 4 x 0x0000) appended after the square wave -> 24 pulses; the output after each fourth 0x0000 = 0x4000 (rounded build).
- Mid-stream reset and back-to-back input: 8 samples with valid_in held high continuously -> 8 consecutive valid_out pulses. Then pulse rst_n low during streaming -> valid_out drops immediately; the next output equals the response to a cleared delay line.

Source files
------------

// File: rtl/fir.sv
// fir: direct-form FIR filter on a signed Q1.15 stream with a 3-stage pipeline and saturated output.
// Define FIR_ROUND_EN for round-half-up output conversion; without it the output truncates toward -inf.
module fir #(
   parameter int NUM_TAPS = 8,
   parameter logic signed [NUM_TAPS*16-1:0] COEFFS = {NUM_TAPS{16'sh1000}}
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               valid_in,
   input  logic signed [15:0] data_in,
   output logic               valid_out,
   output logic signed [15:0] data_out
);
   localparam int ACC_W = 32 + $clog2(NUM_TAPS);
   localparam int SHR_W = ACC_W - 15;
   localparam logic signed [SHR_W-1:0] MAX_V = SHR_W'(32767);
   localparam logic signed [SHR_W-1:0] MIN_V = SHR_W'(-32768);

   logic signed [15:0]      x_reg [NUM_TAPS];
   logic signed [31:0]      prod [NUM_TAPS];
   logic signed [ACC_W-1:0] sum_next;
   logic signed [ACC_W-1:0] acc_reg;
   logic signed [ACC_W-1:0] rnd;
   logic signed [SHR_W-1:0] shr;
   logic signed [15:0]      sat_next;
   logic                    valid_d1_reg;
   logic                    valid_d2_reg;

   // Full-precision products; entry 0 of COEFFS pairs with the newest sample.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
         localparam logic signed [15:0] COEF = COEFFS[gi*16 +: 16];
         assign prod[gi] = 32'(COEF) * 32'(x_reg[gi]);
      end
   endgenerate

   always_comb begin
      sum_next = '0;
      for (int i = 0; i < NUM_TAPS; i++)
         sum_next = sum_next + ACC_W'(prod[i]);
   end

`ifdef FIR_ROUND_EN
   localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(16384);
   assign rnd = acc_reg + HALF_LSB;
`else
   assign rnd = acc_reg;
`endif

   assign shr = SHR_W'(rnd >>> 15);

   always_comb begin
      if (shr > MAX_V)
         sat_next = 16'sh7FFF;
      else if (shr < MIN_V)
         sat_next = 16'sh8000;
      else
         sat_next = shr[15:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_TAPS; i++)
            x_reg[i] <= '0;
         valid_d1_reg <= 1'b0;
         valid_d2_reg <= 1'b0;
         acc_reg      <= '0;
         valid_out    <= 1'b0;
         data_out     <= '0;
      end else begin
         // Idle cycles hold the delay line rather than shifting in zeros.
         if (valid_in) begin
            x_reg[0] <= data_in;
            for (int i = 1; i < NUM_TAPS; i++)
               x_reg[i] <= x_reg[i-1];
         end
         valid_d1_reg <= valid_in;
         valid_d2_reg <= valid_d1_reg;
         if (valid_d1_reg)
            acc_reg <= sum_next;
         valid_out <= valid_d2_reg;
         if (valid_d2_reg)
            data_out <= sat_next;
      end
   end
endmodule

// File: tb/tb_fir.sv
// tb_fir: directed stimulus for fir with a windowed-sum reference model and per-cycle output compare.
// Literal expectations follow the FIR_ROUND_EN build setting.
`timescale 1ns/1ps
module tb_fir;
   localparam int NT = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               valid_in = 1'b0;
   logic signed [15:0] data_in = '0;
   logic               valid_out;
   logic signed [15:0] data_out;

   fir #(.NUM_TAPS(NT)) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
      .valid_out(valid_out), .data_out(data_out)
   );

   always #5 clk = ~clk;

   typedef struct { int val; int due; } exp_t;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   hist [NT];
   int   coef [NT] = '{default: 4096};
   exp_t expq [$];
   int   got [$];
   int   last_out = 0;

`ifdef FIR_ROUND_EN
   int step_lit [8] = '{4096, 8192, 12288, 16384, 20480, 24576, 28672, 32767};
   int sq_lit   [8] = '{4096, 8192, 12288, 16384, 12288, 8192, 4096, 0};
   int rep_lit      = 16384;
   int single_lit   = 4096;
`else
   int step_lit [8] = '{4095, 8191, 12287, 16383, 20479, 24575, 28671, 32767};
   int sq_lit   [8] = '{4095, 8191, 12287, 16383, 12287, 8191, 4095, -1};
   int rep_lit      = 16383;
   int single_lit   = 4095;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, int act, int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d (0x%04h) want %0d (0x%04h) at cycle %0d",
                  name, act, act[15:0], req, req[15:0], cyc);
      end
   endtask

   // Reference: weighted sum of the last NT accepted samples, then shift/round/clamp.
   function automatic int model_out();
      longint acc = 0;
      for (int i = 0; i < NT; i++)
         acc += longint'(coef[i]) * longint'(hist[i]);
`ifdef FIR_ROUND_EN
      acc += 16384;
`endif
      acc = acc >>> 15;
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      return int'(acc);
   endfunction

   task automatic send(int v);
      logic signed [15:0] s;
      exp_t e;
      @(negedge clk);
      s = 16'(v);
      valid_in = 1'b1;
      data_in  = s;
      for (int i = NT - 1; i > 0; i--)
         hist[i] = hist[i-1];
      hist[0] = int'(s);
      e.val = model_out();
      e.due = cyc + 3;
      expq.push_back(e);
      $display("send 0x%04h -> expect %0d at cycle %0d", s, e.val, e.due);
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         valid_in = 1'b0;
      end
   endtask

   task automatic enter_reset();
      rst_n    = 1'b0;
      valid_in = 1'b0;
      expq.delete();
      for (int i = 0; i < NT; i++)
         hist[i] = 0;
      last_out = 0;
   endtask

   task automatic reset_for(int n);
      @(negedge clk);
      enter_reset();
      repeat (n) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Compare process: every cycle, after the active edge has settled.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (!rst_n) begin
            check("rst_valid_out", int'(valid_out), 0);
            check("rst_data_out", int'(data_out), 0);
         end else if (valid_out) begin
            if (expq.size() == 0) begin
               check("spurious_pulse", int'(valid_out), 0);
            end else begin
               exp_t e;
               e = expq.pop_front();
               check("latency", cyc, e.due);
               check("data_out", int'(data_out), e.val);
               $display("pulse cycle %0d data_out=0x%04h want 0x%04h", cyc, data_out, e.val[15:0]);
            end
            got.push_back(int'(data_out));
            last_out = int'(data_out);
         end else begin
            if (expq.size() > 0 && expq[0].due <= cyc) begin
               check("missing_pulse", int'(valid_out), 1);
               void'(expq.pop_front());
            end
            check("hold_data_out", int'(data_out), last_out);
         end
      end
   end

   initial begin
      for (int i = 0; i < NT; i++)
         hist[i] = 0;

      // Reset held for 5 cycles, then idle with no input: no pulses.
      repeat (5) @(negedge clk);
      check("reset_valid_out", int'(valid_out), 0);
      check("reset_data_out", int'(data_out), 0);
      rst_n = 1'b1;
      idle(4);

      // Step response with idle gaps.
      got.delete();
      for (int k = 0; k < 8; k++) begin
         send('h7FFF);
         idle(2);
      end
      idle(5);
      check("step_count", got.size(), 8);
      for (int k = 0; k < 8; k++)
         check($sformatf("step_out%0d", k), got[k], step_lit[k]);

      // Square wave from a cleared state, followed by the repeated pattern.
      reset_for(2);
      idle(2);
      got.delete();
      for (int k = 0; k < 4; k++) send('h7FFF);
      for (int k = 0; k < 4; k++) send('h8000);
      idle(5);
      check("square_count", got.size(), 8);
      for (int k = 0; k < 8; k++)
         check($sformatf("square_out%0d", k), got[k], sq_lit[k]);

      got.delete();
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 4; k++) send('h7FFF);
         for (int k = 0; k < 4; k++) send('h0000);
         idle(1);
      end
      idle(5);
      check("repeat_count", got.size(), 24);
      for (int r = 0; r < 3; r++)
         check($sformatf("repeat_out%0d", r * 8 + 7), got[r * 8 + 7], rep_lit);

      // Back-to-back stream of mixed values.
      reset_for(2);
      got.delete();
      send('h7FFF); send('h8000); send('h1234); send('hF00D);
      send('h4000); send('hC000); send('h0001); send('hFFFF);
      idle(6);
      check("b2b_count", got.size(), 8);

      // Reset asserted while pulses are in flight.
      for (int k = 0; k < 6; k++) send('h7FFF);
      @(negedge clk);
      check("pre_reset_pulse", int'(valid_out), 1);
      enter_reset();
      #1;
      check("async_drop_valid", int'(valid_out), 0);
      check("async_drop_data", int'(data_out), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      got.delete();
      idle(4);
      check("post_reset_no_pulse", got.size(), 0);
      send('h7FFF);
      idle(5);
      check("post_reset_count", got.size(), 1);
      check("post_reset_single", got[0], single_lit);

      idle(4);
      check("queue_drained", expq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
